// File: rtl/jk_excite_driver_if.sv
// Bundle of target-word handshake, J/K drive and q feedback between a control FSM,
// the jk_excite_driver and an external JK register bank.
interface jk_excite_driver_if #(
  parameter int WIDTH = 4,
  parameter int RC_W  = 2
);
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data;
  logic [WIDTH-1:0] j_out;
  logic [WIDTH-1:0] k_out;
  logic [WIDTH-1:0] q_fb;
  logic             done;
  logic             err;
  logic [RC_W-1:0]  retry_cnt;

  // Master is the surrounding environment: controller plus the JK bank feedback.
  modport master (
    output tgt_valid, tgt_data, q_fb,
    input  tgt_ready, j_out, k_out, done, err, retry_cnt
  );

  modport slave (
    input  tgt_valid, tgt_data, q_fb,
    output tgt_ready, j_out, k_out, done, err, retry_cnt
  );
endinterface

// File: rtl/jk_excite_driver.sv
// Converts a target word into JK excitation commands, verifies the bank via q feedback,
// retries up to MAX_RETRY times. Define JK_TOGGLE_EN for toggle (J=K=1) encoding of changes.
module jk_excite_driver #(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 2,
  parameter int RC_W      = 2    // 2**RC_W must exceed MAX_RETRY
) (
  input  logic                clk,
  input  logic                rst_n,
  jk_excite_driver_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic [RC_W-1:0]  retry_q, retry_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] exc_tgt;
  logic [WIDTH-1:0] j_exc;
  logic [WIDTH-1:0] k_exc;
  logic             accept;

  // In IDLE the target is not yet latched, so excite straight from the incoming word.
  assign exc_tgt = (state_q == ST_IDLE) ? bus.tgt_data : tgt_q;
  assign accept  = bus.tgt_valid && ready_q;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_exc
`ifdef JK_TOGGLE_EN
    assign j_exc[gi] = bus.q_fb[gi] ^ exc_tgt[gi];
    assign k_exc[gi] = bus.q_fb[gi] ^ exc_tgt[gi];
`else
    assign j_exc[gi] = ~bus.q_fb[gi] &  exc_tgt[gi];
    assign k_exc[gi] =  bus.q_fb[gi] & ~exc_tgt[gi];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tgt_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
      retry_q <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      j_q     <= j_d;
      k_q     <= k_d;
      retry_q <= retry_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // J/K default to 0 so the bank holds in every state except DRIVE.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    j_d     = '0;
    k_d     = '0;
    retry_d = retry_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          tgt_d   = bus.tgt_data;
          retry_d = '0;
          j_d     = j_exc;
          k_d     = k_exc;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (bus.q_fb == tgt_q) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (retry_q < RC_W'(MAX_RETRY)) begin
          retry_d = retry_q + RC_W'(1);
          j_d     = j_exc;
          k_d     = k_exc;
          state_d = ST_DRIVE;
        end else begin
          err_d   = 1'b1;
          state_d = ST_ERR;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  assign bus.tgt_ready = ready_q;
  assign bus.j_out     = j_q;
  assign bus.k_out     = k_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.retry_cnt = retry_q;

endmodule

// File: tb/tb_jk_excite_driver.sv
// Directed bench for jk_excite_driver with a behavioural JK bank (stuck-bit and
// dropped-drive fault injection). Expected values are hand-computed per vector.
module tb_jk_excite_driver;

`ifdef JK_TOGGLE_EN
  localparam bit TOGGLE = 1'b1;
`else
  localparam bit TOGGLE = 1'b0;
`endif

  logic clk;
  logic rst_n;

  jk_excite_driver_if #(.WIDTH(4), .RC_W(2)) bus ();

  jk_excite_driver #(.WIDTH(4), .MAX_RETRY(2), .RC_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural JK bank: holds through DUT reset; can drop drives or mask bits stuck at 0.
  logic [3:0] bank_q;
  logic [3:0] load_val;
  logic       load_en;
  logic [3:0] stuck_mask;
  int         drop_budget;
  int         dropped;

  always @(posedge clk) begin
    if (load_en) begin
      bank_q  <= load_val;
      dropped <= 0;
    end else if (((bus.j_out | bus.k_out) != 4'b0000) && (dropped < drop_budget)) begin
      dropped <= dropped + 1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        case ({bus.j_out[i], bus.k_out[i]})
          2'b10:   bank_q[i] <= 1'b1;
          2'b01:   bank_q[i] <= 1'b0;
          2'b11:   bank_q[i] <= ~bank_q[i];
          default: bank_q[i] <= bank_q[i];
        endcase
      end
    end
  end

  assign bus.q_fb = bank_q & ~stuck_mask;

  int n_checks;
  int n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [3:0] j_at [0:15];
  logic [3:0] k_at [0:15];
  logic [3:0] exp_j, exp_k;
  int         done_n, err_n;

  task automatic load_bank(input logic [3:0] v, input int budget);
    @(negedge clk);
    load_en     = 1'b1;
    load_val    = v;
    drop_budget = budget;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Offers one word, then records J/K and done/err per cycle n after the accept edge.
  task automatic run_txn(input logic [3:0] tgt, output int d_n, output int e_n);
    int  waited;
    int  n;
    bit  both;
    d_n  = 0;
    e_n  = 0;
    both = 1'b0;
    for (int i = 0; i < 16; i++) begin
      j_at[i] = 4'b0000;
      k_at[i] = 4'b0000;
    end
    @(negedge clk);
    bus.tgt_valid = 1'b1;
    bus.tgt_data  = tgt;
    waited = 0;
    while (!bus.tgt_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("txn_ready", 32'(bus.tgt_ready), 32'd1);
    @(posedge clk);
    n = 0;
    while (n < 12 && d_n == 0 && e_n == 0) begin
      @(negedge clk);
      n++;
      bus.tgt_valid = 1'b0;
      j_at[n] = bus.j_out;
      k_at[n] = bus.k_out;
      if (bus.done) d_n = n;
      if (bus.err)  e_n = n;
      if (bus.done && bus.err) both = 1'b1;
    end
    check("txn_end", 32'((d_n > 0) || (e_n > 0)), 32'd1);
    check("txn_not_both", 32'(both), 32'd0);
    @(negedge clk);
    check("txn_idle_ready", 32'(bus.tgt_ready), 32'd1);
    $display("txn tgt=%b done_n=%0d err_n=%0d retry=%0d q=%b",
             tgt, d_n, e_n, bus.retry_cnt, bus.q_fb);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.tgt_valid = 1'b0;
    bus.tgt_data  = 4'b0000;
    load_en       = 1'b0;
    load_val      = 4'b0000;
    stuck_mask    = 4'b0000;
    drop_budget   = 0;

    // Reset held for 3 clocks, then release; ready rises on the first edge.
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.tgt_ready), 32'd0);
    check("rst_j", 32'(bus.j_out), 32'd0);
    check("rst_k", 32'(bus.k_out), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_retry", 32'(bus.retry_cnt), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_ready_before_edge", 32'(bus.tgt_ready), 32'd0);
    @(negedge clk);
    check("rel_ready_first_edge", 32'(bus.tgt_ready), 32'd1);

    // Bank 0000 -> 1010
    load_bank(4'b0000, 0);
    run_txn(4'b1010, done_n, err_n);
    check("t1_j_drive", 32'(j_at[1]), 32'h0a);
    check("t1_k_drive", 32'(k_at[1]), 32'h0);
    check("t1_j_check", 32'(j_at[2]), 32'h0);
    check("t1_done_n", 32'(done_n), 32'd3);
    check("t1_err_n", 32'(err_n), 32'd0);
    check("t1_retry", 32'(bus.retry_cnt), 32'd0);
    check("t1_q", 32'(bus.q_fb), 32'h0a);

    // Bank 1111 -> 0110
    load_bank(4'b1111, 0);
    run_txn(4'b0110, done_n, err_n);
    exp_j = TOGGLE ? 4'b1001 : 4'b0000;
    exp_k = 4'b1001;
    check("t2_j_drive", 32'(j_at[1]), 32'(exp_j));
    check("t2_k_drive", 32'(k_at[1]), 32'(exp_k));
    check("t2_done_n", 32'(done_n), 32'd3);
    check("t2_err_n", 32'(err_n), 32'd0);
    check("t2_q", 32'(bus.q_fb), 32'h6);

    // Target equal to bank: one idle drive, then done
    run_txn(4'b0110, done_n, err_n);
    check("t3_j_drive", 32'(j_at[1]), 32'h0);
    check("t3_k_drive", 32'(k_at[1]), 32'h0);
    check("t3_done_n", 32'(done_n), 32'd3);

    // Bank drops the first drive: one retry, done two cycles later
    load_bank(4'b0011, 1);
    run_txn(4'b1100, done_n, err_n);
    exp_j = TOGGLE ? 4'b1111 : 4'b1100;
    exp_k = TOGGLE ? 4'b1111 : 4'b0011;
    check("t4_j_drive1", 32'(j_at[1]), 32'(exp_j));
    check("t4_k_drive1", 32'(k_at[1]), 32'(exp_k));
    check("t4_j_drive2", 32'(j_at[3]), 32'(exp_j));
    check("t4_k_drive2", 32'(k_at[3]), 32'(exp_k));
    check("t4_done_n", 32'(done_n), 32'd5);
    check("t4_retry", 32'(bus.retry_cnt), 32'd1);

    // Bit0 stuck at 0: three drives, err at cycle 7, retries exhausted
    load_bank(4'b0000, 0);
    stuck_mask = 4'b0001;
    run_txn(4'b0001, done_n, err_n);
    exp_k = TOGGLE ? 4'b0001 : 4'b0000;
    check("t5_j_drive1", 32'(j_at[1]), 32'h1);
    check("t5_j_drive2", 32'(j_at[3]), 32'h1);
    check("t5_j_drive3", 32'(j_at[5]), 32'h1);
    check("t5_k_drive3", 32'(k_at[5]), 32'(exp_k));
    check("t5_err_n", 32'(err_n), 32'd7);
    check("t5_done_n", 32'(done_n), 32'd0);
    check("t5_retry", 32'(bus.retry_cnt), 32'd2);
    @(negedge clk);
    check("t5_retry_hold", 32'(bus.retry_cnt), 32'd2);
    stuck_mask = 4'b0000;

    // Reset during DRIVE: J/K clear at once, no done/err, bank untouched
    load_bank(4'b0000, 0);
    @(negedge clk);
    bus.tgt_valid = 1'b1;
    bus.tgt_data  = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    bus.tgt_valid = 1'b0;
    check("t6_j_before", 32'(bus.j_out), 32'hf);
    rst_n = 1'b0;
    #1;
    check("t6_j_reset", 32'(bus.j_out), 32'h0);
    check("t6_k_reset", 32'(bus.k_out), 32'h0);
    check("t6_ready_reset", 32'(bus.tgt_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t6_no_done", 32'(bus.done), 32'd0);
      check("t6_no_err", 32'(bus.err), 32'd0);
    end
    check("t6_bank_held", 32'(bus.q_fb), 32'h0);
    $display("txn tgt=1111 aborted by reset q=%b", bus.q_fb);
    run_txn(4'b1111, done_n, err_n);
    check("t6_after_done_n", 32'(done_n), 32'd3);
    check("t6_after_q", 32'(bus.q_fb), 32'hf);

    // Back-to-back: valid held, data changes while busy are ignored
    load_bank(4'b0000, 0);
    @(negedge clk);
    bus.tgt_valid = 1'b1;
    bus.tgt_data  = 4'b0101;
    @(posedge clk);
    @(negedge clk);
    check("t7_j_a", 32'(bus.j_out), 32'h5);
    check("t7_busy_ready", 32'(bus.tgt_ready), 32'd0);
    bus.tgt_data = 4'b1111;
    @(negedge clk);
    bus.tgt_data = 4'b1010;
    @(negedge clk);
    check("t7_done_a", 32'(bus.done), 32'd1);
    check("t7_ready_at_done", 32'(bus.tgt_ready), 32'd0);
    bus.tgt_data = 4'b0011;
    @(negedge clk);
    check("t7_idle_ready", 32'(bus.tgt_ready), 32'd1);
    check("t7_q_a", 32'(bus.q_fb), 32'h5);
    $display("txn tgt=0101 back-to-back first q=%b", bus.q_fb);
    @(negedge clk);
    bus.tgt_valid = 1'b0;
    exp_j = TOGGLE ? 4'b0110 : 4'b0010;
    exp_k = TOGGLE ? 4'b0110 : 4'b0100;
    check("t7_j_b", 32'(bus.j_out), 32'(exp_j));
    check("t7_k_b", 32'(bus.k_out), 32'(exp_k));
    repeat (2) @(negedge clk);
    check("t7_done_b", 32'(bus.done), 32'd1);
    check("t7_q_b", 32'(bus.q_fb), 32'h3);
    $display("txn tgt=0011 back-to-back second q=%b", bus.q_fb);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
